prio_enc_q: RTL and testbench
=============================

PRIO_ENC_Q -- requirements
Module: prio_enc_q

Interface
REQ-001 Parameter: N, default 8, number of request inputs; legal range 2..32, need not be a power of 2.
REQ-002 Parameter: W, default $clog2(N), index width; not overridden by instantiators.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: en  in  1  request capture enable.
REQ-006 Port: req  in  N  request bits, one per source; sampled only when en=1.
REQ-007 Port: out_valid  out  1  registered; an index is offered.
REQ-008 Port: out_ready  in  1  consumer accepts the offered index.
REQ-009 Port: out_idx  out  W  registered; offered source index.
REQ-010 Port: pend_cnt  out  $clog2(N+1)  count of requests waiting, excluding the offered one.
REQ-011 Port: any_pend  out  1  1 when out_valid=1 or any request is waiting.

Function
REQ-012 State SHALL be: pending register P[N-1:0], plus output register {out_valid, out_idx}; a request bit is in exactly one place: waiting in P, or offered.
REQ-013 Candidate set SHALL be C = P | (en ? req : 0); req is ignored when en=0, and P still drains.
REQ-014 Load condition L = (!out_valid || out_ready); at an edge with L=1 and C!=0: out_valid<=1, out_idx<=sel(C), P<=C with bit sel(C) cleared.
REQ-015 At an edge with L=1 and C==0: out_valid<=0, out_idx<=0, P<=0.
REQ-016 At an edge with L=0 (stall): out_valid and out_idx SHALL hold; P<=C.
REQ-017 Latency: a req bit captured in cycle t, with the output empty, SHALL appear on out_idx in cycle t+1.
REQ-018 A req bit equal to the currently offered index SHALL set P; that source is offered again later (no merging).
REQ-019 Repeated req on a bit already in P SHALL have no additional effect; the block does not flag overflow.
REQ-020 Fixed-priority sel(C) SHALL be the highest set index of C.
REQ-021 Handshake SHALL complete in the cycle where out_valid=1 and out_ready=1; with back-to-back ready and continuous work, one index is issued per cycle.
REQ-022 pend_cnt SHALL equal popcount(P) and any_pend SHALL equal out_valid | (|P), both derived from registered state only.

Reset
REQ-023 While rst=1: P=0, out_valid=0, out_idx=0, pend_cnt=0, any_pend=0, and the round-robin pointer is 0, regardless of clk.
REQ-024 Reset asserted mid-operation SHALL discard all pending and offered requests; the first capture after deassertion starts from the empty state.

Configuration
REQ-025 Macro PRIO_ENC_Q_RR_EN defined: sel(C) SHALL be the first set index searching ascending from pointer ptr (W bits), wrapping modulo N; on each edge with a load, ptr <= (sel(C)+1) mod N.
REQ-026 PRIO_ENC_Q_RR_EN undefined: no pointer register exists and REQ-020 fixed priority applies.

Verification (N=8)
REQ-027 Assert rst asynchronously between edges -> out_valid=0, out_idx=0, pend_cnt=0, any_pend=0 immediately.
REQ-028 Fixed mode; en=1, req=8'b0100_1010 for one cycle t, out_ready=1 -> out_idx 6,3,1 in cycles t+1..t+3, with pend_cnt 2,1,0; out_valid=0 at t+4.
REQ-029 out_ready=0 while idx 3 is offered; req=8'h80 arrives -> out_idx stays 3, pend_cnt=1; out_ready=1 -> 7 is offered in the next cycle.
REQ-030 en=0, req=8'hFF for 4 cycles from empty -> out_valid=0, pend_cnt=0 throughout.
REQ-031 Idx 5 is offered with out_ready=0; req=8'h20 again -> pend_cnt=1; after acceptance, 5 is offered again in the next cycle.
REQ-032 PRIO_ENC_Q_RR_EN defined; req=8'hFF held with en=1, out_ready=1 -> out_idx sequence 0,1,2,...,7,0,1.

Source files
------------

// File: rtl/prio_enc_q.sv
// prio_enc_q: queued priority encoder with a valid/ready output stage.
// Requests accumulate in a pending register and are issued one index per
// accepted handshake. By default selection is fixed priority (highest set
// index wins). Define PRIO_ENC_Q_RR_EN to select round-robin arbitration with
// a rotating search pointer instead.
module prio_enc_q #(
   parameter int unsigned N = 8,
   parameter int unsigned W = $clog2(N)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [N-1:0]             req,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [W-1:0]             out_idx,
   output logic [$clog2(N+1)-1:0]   pend_cnt,
   output logic                     any_pend
);

   localparam int unsigned CW = $clog2(N + 1);

   logic [N-1:0]  pend_q, pend_d;
   logic          valid_q, valid_d;
   logic [W-1:0]  idx_q, idx_d;
   logic [N-1:0]  cand;
   logic          load;
   logic [W-1:0]  sel;
   logic [CW-1:0] cnt;

   assign cand = pend_q | (en ? req : '0);
   assign load = !valid_q || out_ready;

`ifdef PRIO_ENC_Q_RR_EN
   logic [W-1:0] ptr_q, ptr_d;

   // Round-robin: first set candidate searching upward from ptr, wrapping at N.
   always_comb begin
      logic        found;
      int unsigned j;
      sel   = '0;
      found = 1'b0;
      j     = 0;
      for (int unsigned k = 0; k < N; k++) begin
         j = k + 32'(ptr_q);
         if (j >= N) begin
            j = j - N;
         end
         if (!found && cand[W'(j)]) begin
            sel   = W'(j);
            found = 1'b1;
         end
      end
   end

   // Pointer moves just past the index issued on every load.
   always_comb begin
      ptr_d = ptr_q;
      if (load && (|cand)) begin
         ptr_d = (sel == W'(N - 1)) ? '0 : sel + W'(1);
      end
   end

   // Pointer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   // Fixed priority: highest set candidate index wins (last match overrides).
   always_comb begin
      sel = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (cand[i]) begin
            sel = W'(i);
         end
      end
   end
`endif

   // Next state: load a new offer when the output is free or being accepted,
   // otherwise hold the offer and just fold new requests into pending.
   always_comb begin
      valid_d = valid_q;
      idx_d   = idx_q;
      pend_d  = cand;
      if (load) begin
         if (|cand) begin
            valid_d     = 1'b1;
            idx_d       = sel;
            pend_d[sel] = 1'b0;
         end else begin
            valid_d = 1'b0;
            idx_d   = '0;
            pend_d  = '0;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q  <= '0;
         valid_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         pend_q  <= pend_d;
         valid_q <= valid_d;
         idx_q   <= idx_d;
      end
   end

   // Population count of waiting requests.
   always_comb begin
      cnt = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cnt = cnt + CW'(pend_q[i]);
      end
   end

   assign out_valid = valid_q;
   assign out_idx   = idx_q;
   assign pend_cnt  = cnt;
   assign any_pend  = valid_q | (|pend_q);

endmodule

// File: tb/tb_prio_enc_q.sv
// Directed testbench for prio_enc_q (N=8). Fixed-priority vectors run in the
// default build; the round-robin sequence runs when PRIO_ENC_Q_RR_EN is set.
module tb_prio_enc_q;

   localparam int unsigned N = 8;
   localparam int unsigned W = 3;

   logic         clk;
   logic         rst;
   logic         en;
   logic [N-1:0] req;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_idx;
   logic [3:0]   pend_cnt;
   logic         any_pend;

   int n_checks = 0;
   int n_errors = 0;

   prio_enc_q #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req       (req),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .pend_cnt  (pend_cnt),
      .any_pend  (any_pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      en        = 1'b0;
      req       = '0;
      out_ready = 1'b0;
      rst       = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic check_out(input string tag, input logic v, input logic [W-1:0] idx,
                            input logic [3:0] cnt);
      check({tag, ".valid"}, 32'(out_valid), 32'(v));
      if (v) check({tag, ".idx"}, 32'(out_idx), 32'(idx));
      check({tag, ".cnt"}, 32'(pend_cnt), 32'(cnt));
      check({tag, ".any"}, 32'(any_pend), 32'(v | (cnt != 0)));
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; req = '0; out_ready = 1'b0;
      #12;
      check_out("rst_hold", 1'b0, 3'd0, 4'd0);
      check("rst_hold.idx0", 32'(out_idx), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Asynchronous reset between edges discards state immediately.
      en = 1'b1; req = 8'hC0; out_ready = 1'b0;
      step();
      check_out("pre_rst", 1'b1, 3'd7, 4'd1);
      en = 1'b0; req = '0;
      #2 rst = 1'b1;
      #1;
      check_out("async_rst", 1'b0, 3'd0, 4'd0);
      check("async_rst.idx0", 32'(out_idx), 32'd0);
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      step();
      check_out("post_rst_empty", 1'b0, 3'd0, 4'd0);
      en = 1'b1; req = 8'h04;
      step();
      check_out("post_rst_cap", 1'b1, 3'd2, 4'd0);

`ifdef PRIO_ENC_Q_RR_EN
      // Round-robin under saturating load.
      do_reset();
      en = 1'b1; req = 8'hFF; out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check($sformatf("rr[%0d].idx", i), 32'(out_idx), 32'(i % 8));
         check($sformatf("rr[%0d].valid", i), 32'(out_valid), 32'd1);
      end
`else
      // Three requests drain highest first, one per cycle.
      do_reset();
      en = 1'b1; req = 8'b0100_1010; out_ready = 1'b1;
      step();
      check_out("drain1", 1'b1, 3'd6, 4'd2);
      en = 1'b0; req = '0;
      step();
      check_out("drain2", 1'b1, 3'd3, 4'd1);
      step();
      check_out("drain3", 1'b1, 3'd1, 4'd0);
      step();
      check_out("drain4", 1'b0, 3'd0, 4'd0);

      // Stall holds the offer while a new request waits.
      do_reset();
      en = 1'b1; req = 8'h08; out_ready = 1'b1;
      step();
      check_out("stall_a", 1'b1, 3'd3, 4'd0);
      out_ready = 1'b0; req = 8'h80;
      step();
      check_out("stall_b", 1'b1, 3'd3, 4'd1);
      en = 1'b0; req = '0;
      step();
      check_out("stall_c", 1'b1, 3'd3, 4'd1);
      out_ready = 1'b1;
      step();
      check_out("stall_d", 1'b1, 3'd7, 4'd0);
      step();
      check_out("stall_e", 1'b0, 3'd0, 4'd0);

      // Disabled capture ignores requests.
      do_reset();
      en = 1'b0; req = 8'hFF; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check_out($sformatf("en0[%0d]", i), 1'b0, 3'd0, 4'd0);
      end

      // Request for the offered index is queued again, not merged.
      do_reset();
      en = 1'b1; req = 8'h20; out_ready = 1'b0;
      step();
      check_out("reoffer_a", 1'b1, 3'd5, 4'd0);
      step();
      check_out("reoffer_b", 1'b1, 3'd5, 4'd1);
      step();
      check_out("reoffer_dup", 1'b1, 3'd5, 4'd1);
      en = 1'b0; req = '0; out_ready = 1'b1;
      step();
      check_out("reoffer_c", 1'b1, 3'd5, 4'd0);
      step();
      check_out("reoffer_d", 1'b0, 3'd0, 4'd0);

      // Continuous work: the highest source keeps winning each cycle.
      do_reset();
      en = 1'b1; req = 8'h0F; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_out($sformatf("b2b[%0d]", i), 1'b1, 3'd3, 4'd3);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
